// File: rtl/io_seq_pkg.sv
// Shared constants and helpers for the I/O load sequencer: FSM state codes,
// error codes, phase codes and the per-phase expected word count.
package io_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] PH_CNN  = 2'd0;
  localparam logic [1:0] PH_FC   = 2'd1;
  localparam logic [1:0] PH_IMG  = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

  function automatic int unsigned exp_words(input logic [1:0]  ph,
                                            input int unsigned cnn,
                                            input int unsigned fc,
                                            input int unsigned img);
    int unsigned w;
    case (ph)
      PH_CNN:  w = cnn;
      PH_FC:   w = fc;
      PH_IMG:  w = img;
      default: w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/io_load_sequencer_if.sv
// Handshake bundle between the load sequencer, the three loaders and the
// compute core. The sequencer uses the master modport.
interface io_load_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             load_cnn;
  logic             load_fc;
  logic             load_img;
  logic             finish_cnn;
  logic             finish_fc;
  logic             finish_img;
  logic             wr_strobe;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [1:0]       phase;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    input  start, finish_cnn, finish_fc, finish_img, wr_strobe,
    output load_cnn, load_fc, load_img, busy, done, error, err_code, phase, word_cnt
  );

  modport slave (
    output start, finish_cnn, finish_fc, finish_img, wr_strobe,
    input  load_cnn, load_fc, load_img, busy, done, error, err_code, phase, word_cnt
  );
endinterface

// File: rtl/io_seq_watchdog.sv
// Per-phase inactivity watchdog: counts while enabled, clears on request,
// flags expiry at TIMEOUT_CYC-1. Only instantiated under IO_SEQ_WATCHDOG_EN.
module io_seq_watchdog #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIM = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIM))
      cnt_d = cnt_q + TO_W'(1);
  end

  // A strobe in the same cycle counts as activity and suppresses expiry.
  assign expired_o = en_i && !clr_i && (cnt_q == LIM);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_load_sequencer.sv
// Load sequencer: runs CNN -> FC -> IMG load phases, checks word counts and
// reports done/error. Optional inactivity watchdog under IO_SEQ_WATCHDOG_EN.
module io_load_sequencer
  import io_seq_pkg::*;
#(
  parameter int CNN_WORDS   = 50704,
  parameter int FC_WORDS    = 11218,
  parameter int IMG_WORDS   = 1024,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  io_load_sequencer_if.master bus
);

  if ((CNN_WORDS > (2**CNT_W) - 1) || (FC_WORDS > (2**CNT_W) - 1) ||
      (IMG_WORDS > (2**CNT_W) - 1)) begin : g_bad_cnt_w
    $error("io_load_sequencer: a phase word count does not fit in CNT_W bits");
  end
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC - 1 > (2**TO_W) - 1)) begin : g_bad_to_w
    $error("io_load_sequencer: TIMEOUT_CYC out of range for TO_W");
  end

  logic [2:0]       st_q, st_d;
  logic [1:0]       ph_q, ph_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fin_prev_q;
  logic [2:0]       fin_now;
  logic             rise;
  logic [CNT_W-1:0] exp_w;
  logic [CNT_W:0]   eff;
  logic             wd_exp;
  logic             wd_clr;
  logic             wd_en;

  assign fin_now = {bus.finish_img, bus.finish_fc, bus.finish_cnn};
  assign exp_w   = CNT_W'(exp_words(ph_q, CNN_WORDS, FC_WORDS, IMG_WORDS));
  assign eff     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, bus.wr_strobe};

  always_comb begin
    rise = 1'b0;
    case (ph_q)
      PH_CNN:  rise = fin_now[0] & ~fin_prev_q[0];
      PH_FC:   rise = fin_now[1] & ~fin_prev_q[1];
      PH_IMG:  rise = fin_now[2] & ~fin_prev_q[2];
      default: rise = 1'b0;
    endcase
  end

  assign wd_clr = (st_q == ST_ISSUE) || bus.wr_strobe;
  assign wd_en  = (st_q == ST_WAIT);

`ifdef IO_SEQ_WATCHDOG_EN
  io_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_exp)
  );
`else
  assign wd_exp = 1'b0 & wd_clr & wd_en;
`endif

  // Priority in WAIT: overrun, then finish evaluation, then timeout.
  always_comb begin
    st_d  = st_q;
    ph_d  = ph_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          st_d  = ST_ISSUE;
          ph_d  = PH_CNN;
          err_d = ERR_NONE;
          cnt_d = '0;
        end
      end
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.wr_strobe && (cnt_q == exp_w)) begin
          st_d  = ST_ERR;
          err_d = ERR_OVERRUN;
        end else if (rise) begin
          cnt_d = eff[CNT_W-1:0];
          if (eff == {1'b0, exp_w}) begin
            if (ph_q == PH_IMG) begin
              st_d = ST_DONE;
              ph_d = PH_NONE;
            end else begin
              st_d  = ST_ISSUE;
              ph_d  = ph_q + 2'd1;
              cnt_d = '0;
            end
          end else begin
            st_d  = ST_ERR;
            err_d = ERR_SHORT;
          end
        end else if (wd_exp) begin
          st_d  = ST_ERR;
          err_d = ERR_TIMEOUT;
        end else if (bus.wr_strobe) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Finish levels are sampled every cycle, so entering ISSUE re-arms edge
  // detection and finish flags left high by an earlier run are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      ph_q       <= PH_NONE;
      err_q      <= ERR_NONE;
      cnt_q      <= '0;
      fin_prev_q <= '0;
    end else begin
      st_q       <= st_d;
      ph_q       <= ph_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      fin_prev_q <= fin_now;
    end
  end

  assign bus.load_cnn = (st_q == ST_ISSUE) && (ph_q == PH_CNN);
  assign bus.load_fc  = (st_q == ST_ISSUE) && (ph_q == PH_FC);
  assign bus.load_img = (st_q == ST_ISSUE) && (ph_q == PH_IMG);
  assign bus.busy     = (st_q == ST_ISSUE) || (st_q == ST_WAIT);
  assign bus.done     = (st_q == ST_DONE);
  assign bus.error    = (st_q == ST_ERR);
  assign bus.err_code = err_q;
  assign bus.phase    = ph_q;
  assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_io_load_sequencer.sv
// Self-checking bench for io_load_sequencer: vector table, directed phase
// runs and randomized runs scored against a phase-outcome model.
module tb_io_load_sequencer;

  localparam int CNN   = 60;
  localparam int FC    = 35;
  localparam int IMG   = 20;
  localparam int CW    = 16;
  localparam int TO    = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  io_load_sequencer_if #(.CNT_W(CW)) bus ();

  io_load_sequencer #(
    .CNN_WORDS(CNN), .FC_WORDS(FC), .IMG_WORDS(IMG),
    .CNT_W(CW), .TIMEOUT_CYC(TO), .TO_W(20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int load_log[$];

  always @(negedge clk) begin
    if (bus.load_cnn === 1'b1) load_log.push_back(0);
    if (bus.load_fc  === 1'b1) load_log.push_back(1);
    if (bus.load_img === 1'b1) load_log.push_back(2);
  end

  typedef struct {
    bit       rst_n, start, wr;
    bit [2:0] fin;     // {img, fc, cnn}
    bit [2:0] e_load;  // {img, fc, cnn}
    bit       e_busy, e_done, e_err;
    bit [1:0] e_code, e_ph;
    int       e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit w, bit [2:0] f, bit [2:0] l,
                              bit b, bit d, bit e, bit [1:0] c, bit [1:0] p, int n);
    vec_t v;
    v.rst_n = r; v.start = s; v.wr = w; v.fin = f; v.e_load = l;
    v.e_busy = b; v.e_done = d; v.e_err = e; v.e_code = c; v.e_ph = p; v.e_cnt = n;
    return v;
  endfunction

  function automatic logic [25:0] outs();
    return {bus.load_img, bus.load_fc, bus.load_cnn, bus.busy, bus.done, bus.error,
            bus.err_code, bus.phase, bus.word_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_fin(input int p, input bit v);
    case (p)
      0: bus.finish_cnn = v;
      1: bus.finish_fc  = v;
      default: bus.finish_img = v;
    endcase
  endtask

  function automatic bit cur_load(input int p);
    case (p)
      0: return bus.load_cnn;
      1: return bus.load_fc;
      default: return bus.load_img;
    endcase
  endfunction

  task automatic wait_load(input int p, output bit ok);
    int w = 0;
    ok = 1'b0;
    while (w < 5) begin
      if (cur_load(p)) begin
        ok = 1'b1;
        break;
      end
      tick();
      w++;
    end
    chk($sformatf("load%0d_latency", p), ok ? w : 99, 0);
  endtask

  function automatic int exp_of(input int p);
    return (p == 0) ? CNN : (p == 1) ? FC : IMG;
  endfunction

  // One full sequence; expectations come from the per-phase count outcome.
  task automatic run_trial(input int n0, input int n1, input int n2,
                           input bit same, input bit hold, input string tag);
    int  n[3];
    int  fail_ph, e_code, e_cnt, e_ph, nloads, base, lim, good;
    bit  e_done, ok;
    n = '{n0, n1, n2};
    fail_ph = -1; e_code = 0; e_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      if (fail_ph < 0) begin
        if (n[p] > exp_of(p)) begin
          fail_ph = p; e_code = 2; e_cnt = exp_of(p);
        end else if (n[p] < exp_of(p)) begin
          fail_ph = p; e_code = 1; e_cnt = n[p];
        end
      end
    end
    e_done = (fail_ph < 0);
    e_ph   = e_done ? 3 : fail_ph;
    nloads = e_done ? 3 : fail_ph + 1;

    bus.finish_cnn = 0; bus.finish_fc = 0; bus.finish_img = 0; bus.wr_strobe = 0;
    tick();
    base = load_log.size();
    bus.start = 1; tick(); bus.start = 0;
    for (int p = 0; p < 3; p++) begin
      wait_load(p, ok);
      if (!ok) break;
      tick();
      lim = (n[p] > exp_of(p)) ? exp_of(p) + 1 : n[p];
      for (int i = 0; i < lim; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        bus.wr_strobe = 1;
        if (same && i == lim - 1 && n[p] <= exp_of(p)) set_fin(p, 1);
        tick();
        bus.wr_strobe = 0;
      end
      if (n[p] > exp_of(p)) break;
      if (!same) begin
        set_fin(p, 1);
        tick();
      end
      if (!hold) set_fin(p, 0);
      if (n[p] < exp_of(p)) break;
    end

    chk({tag, "_done"},  bus.done, e_done);
    chk({tag, "_error"}, bus.error, !e_done);
    chk({tag, "_code"},  bus.err_code, e_code);
    chk({tag, "_phase"}, bus.phase, e_ph);
    chk({tag, "_busy"},  bus.busy, 0);
    if (!e_done) chk({tag, "_wcnt"}, bus.word_cnt, e_cnt);
    good = (load_log.size() - base == nloads);
    if (good)
      for (int i = 0; i < nloads; i++)
        if (load_log[base + i] != i) good = 0;
    chk({tag, "_loads"}, good, 1);
    tick();
    chk({tag, "_held"}, {bus.done, bus.error}, {e_done, !e_done});
  endtask

  // Finish lines are already high; only fresh rising edges may advance.
  task automatic sticky_run();
    bit ok;
    bus.start = 1; tick(); bus.start = 0;
    for (int p = 0; p < 3; p++) begin
      wait_load(p, ok);
      if (!ok) break;
      tick();
      repeat (exp_of(p)) begin
        bus.wr_strobe = 1; tick();
      end
      bus.wr_strobe = 0;
      tick(); tick();
      chk($sformatf("sticky_wait%0d", p), {bus.busy, bus.phase}, {1'b1, 2'(p)});
      set_fin(p, 0); tick();
      set_fin(p, 1); tick();
    end
    chk("sticky_done", {bus.done, bus.err_code}, {1'b1, 2'd0});
  endtask

  vec_t tv[17];

  initial begin
    bit ok;
    bus.start = 0; bus.wr_strobe = 0;
    bus.finish_cnn = 0; bus.finish_fc = 0; bus.finish_img = 0;

    tv[0]  = mk(0,0,0,3'b000, 3'b000,0,0,0,0,3,0);
    tv[1]  = mk(1,0,0,3'b000, 3'b000,0,0,0,0,3,0);
    tv[2]  = mk(1,1,0,3'b000, 3'b001,1,0,0,0,0,0);
    tv[3]  = mk(1,0,0,3'b000, 3'b000,1,0,0,0,0,0);
    tv[4]  = mk(1,0,1,3'b000, 3'b000,1,0,0,0,0,1);
    tv[5]  = mk(1,1,1,3'b000, 3'b000,1,0,0,0,0,2);
    tv[6]  = mk(1,0,0,3'b010, 3'b000,1,0,0,0,0,2);
    tv[7]  = mk(1,0,1,3'b000, 3'b000,1,0,0,0,0,3);
    tv[8]  = mk(1,0,0,3'b001, 3'b000,0,0,1,1,0,3);
    tv[9]  = mk(1,0,0,3'b001, 3'b000,0,0,1,1,0,3);
    tv[10] = mk(1,1,0,3'b001, 3'b001,1,0,0,0,0,0);
    tv[11] = mk(1,0,0,3'b001, 3'b000,1,0,0,0,0,0);
    tv[12] = mk(1,0,1,3'b001, 3'b000,1,0,0,0,0,1);
    tv[13] = mk(1,0,1,3'b000, 3'b000,1,0,0,0,0,2);
    tv[14] = mk(0,0,0,3'b000, 3'b000,0,0,0,0,3,0);
    tv[15] = mk(1,1,0,3'b000, 3'b001,1,0,0,0,0,0);
    tv[16] = mk(0,0,0,3'b000, 3'b000,0,0,0,0,3,0);

    for (int i = 0; i < 17; i++) begin
      rst_n = tv[i].rst_n; bus.start = tv[i].start; bus.wr_strobe = tv[i].wr;
      {bus.finish_img, bus.finish_fc, bus.finish_cnn} = tv[i].fin;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {tv[i].e_load, tv[i].e_busy, tv[i].e_done, tv[i].e_err,
           tv[i].e_code, tv[i].e_ph, 16'(tv[i].e_cnt)});
    end
    rst_n = 1; bus.start = 0; bus.wr_strobe = 0;
    bus.finish_cnn = 0; bus.finish_fc = 0; bus.finish_img = 0;
    tick();

    run_trial(CNN, FC, IMG, 0, 0, "nominal");
    run_trial(CNN, FC - 1, IMG, 0, 0, "short_fc");
    run_trial(CNN, FC, IMG + 1, 0, 0, "overrun_img");
    run_trial(CNN, FC, IMG, 1, 1, "same_cycle_hold");
    sticky_run();
    do_reset();

    bus.finish_cnn = 0; bus.finish_fc = 0; bus.finish_img = 0;
    bus.start = 1; tick(); bus.start = 0;
    wait_load(0, ok);
    tick();
    repeat (TO - 1) tick();
    chk("wd_before_limit", {bus.busy, bus.error}, 2'b10);
    tick();
`ifdef IO_SEQ_WATCHDOG_EN
    chk("wd_timeout", {bus.error, bus.err_code, bus.phase}, {1'b1, 2'd3, 2'd0});
`else
    chk("wd_absent", {bus.busy, bus.error, bus.err_code}, {1'b1, 1'b0, 2'd0});
`endif
    do_reset();

    bus.start = 1; tick(); bus.start = 0;
    wait_load(0, ok);
    tick();
    repeat (CNN) begin
      bus.wr_strobe = 1; tick();
    end
    bus.wr_strobe = 0;
    set_fin(0, 1); tick(); set_fin(0, 0);
    wait_load(1, ok);
    tick();
    repeat (5) begin
      bus.wr_strobe = 1; tick();
    end
    bus.wr_strobe = 0;
    bus.start = 1; tick(); bus.start = 0;
    chk("busy_start_ignored", outs(), {3'b000, 3'b100, 2'd0, 2'd1, 16'd5});
    rst_n = 0; tick(); rst_n = 1;
    chk("mid_fc_reset", outs(), {3'b000, 3'b000, 2'd0, 2'd3, 16'd0});
    tick();
    chk("post_reset_idle", outs(), {3'b000, 3'b000, 2'd0, 2'd3, 16'd0});
    bus.start = 1; tick(); bus.start = 0;
    chk("restart_load_cnn", {bus.load_img, bus.load_fc, bus.load_cnn, bus.phase},
        {3'b001, 2'd0});
    do_reset();

    for (int t = 0; t < 25; t++) begin
      int nn[3];
      for (int p = 0; p < 3; p++) begin
        int r = $urandom_range(0, 9);
        if (r < 7)      nn[p] = exp_of(p);
        else if (r < 9) nn[p] = exp_of(p) - $urandom_range(1, 3);
        else            nn[p] = exp_of(p) + $urandom_range(1, 3);
      end
      run_trial(nn[0], nn[1], nn[2], 1'($urandom_range(0, 1)), 0,
                $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
